// File: rtl/aurora_rx_packet_filter.sv
// Store-and-forward filter behind the Aurora RX stream: frames are buffered and only
// released downstream once their last beat reports a valid, passing CRC.
module aurora_rx_packet_filter #(
   parameter int ADDR_WIDTH    = 9,
   parameter int MAX_PKT_WORDS = 256,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic [31:0]          sAxisTdata,
   input  logic [3:0]           sAxisTkeep,
   input  logic [7:0]           sAxisTuser,
   input  logic                 sAxisTlast,
   input  logic                 sAxisTvalid,
   output logic [31:0]          mAxisTdata,
   output logic [3:0]           mAxisTkeep,
   output logic                 mAxisTlast,
   output logic                 mAxisTvalid,
   input  logic                 mAxisTready,
   input  logic                 clearCounters,
   output logic [CNT_WIDTH-1:0] goodPktCount,
   output logic [CNT_WIDTH-1:0] crcErrCount,
   output logic [CNT_WIDTH-1:0] dropCount,
   output logic [ADDR_WIDTH:0]  fifoLevel,
   output logic [1:0]           wrStateDbg
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam int BW = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [PW-1:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [BW-1:0] MAX_BEAT = BW'(MAX_PKT_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DISCARD = 2'd2} wrState_t;
   wrState_t wrState, wrStateNext;

   logic [36:0]   mem [0:(1<<ADDR_WIDTH)-1];
   logic [36:0]   rdWord;
   logic [PW-1:0] wrPtr, wrPtrNext, wrCommit, wrCommitNext;
   logic [PW-1:0] rdAddr, rdPtr;
   logic [BW-1:0] beatCnt, beatCntNext;
   logic          wrEn, incGood, incCrc, incDrop, full;
   logic          memQValid, moveOut, rdIssue, consume;
   logic          unusedUserBits;

   assign unusedUserBits = ^sAxisTuser[7:2];
   assign wrStateDbg     = wrState;

   // rdPtr only advances on a downstream handshake, so full is conservative and
   // fifoLevel counts every committed word the consumer has not yet taken.
   assign full      = ((wrPtr - rdPtr) == DEPTH);
   assign fifoLevel = wrCommit - rdPtr;

   always_comb begin
      wrStateNext  = wrState;
      wrPtrNext    = wrPtr;
      wrCommitNext = wrCommit;
      beatCntNext  = beatCnt;
      wrEn         = 1'b0;
      incGood      = 1'b0;
      incCrc       = 1'b0;
      incDrop      = 1'b0;
      if (sAxisTvalid) begin
         case (wrState)
            IDLE, RECV: begin
               if (full || beatCnt == MAX_BEAT) begin
                  if (sAxisTlast) begin
                     wrPtrNext   = wrCommit;
                     beatCntNext = '0;
                     incDrop     = 1'b1;
                     wrStateNext = IDLE;
                  end else begin
                     wrStateNext = DISCARD;
                  end
               end else begin
                  wrEn = 1'b1;
                  if (sAxisTlast) begin
                     beatCntNext = '0;
                     wrStateNext = IDLE;
                     if (sAxisTuser[1:0] == 2'b11) begin
                        wrPtrNext    = wrPtr + 1'b1;
                        wrCommitNext = wrPtr + 1'b1;
                        incGood      = 1'b1;
                     end else begin
                        wrPtrNext = wrCommit;
                        incCrc    = 1'b1;
                     end
                  end else begin
                     wrPtrNext   = wrPtr + 1'b1;
                     beatCntNext = beatCnt + 1'b1;
                     wrStateNext = RECV;
                  end
               end
            end
            DISCARD: begin
               if (sAxisTlast) begin
                  wrPtrNext   = wrCommit;
                  beatCntNext = '0;
                  incDrop     = 1'b1;
                  wrStateNext = IDLE;
               end
            end
            default: wrStateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wrState  <= IDLE;
         wrPtr    <= '0;
         wrCommit <= '0;
         beatCnt  <= '0;
      end else begin
         wrState  <= wrStateNext;
         wrPtr    <= wrPtrNext;
         wrCommit <= wrCommitNext;
         beatCnt  <= beatCntNext;
      end
   end

   // Output handshake: a beat transfers on a rising edge where mAxisTvalid and
   // mAxisTready are both high; once valid is raised the beat is held unchanged
   // until it transfers. memQ is the word in flight from the one-cycle memory read.
   assign consume = mAxisTvalid && mAxisTready;
   assign moveOut = memQValid && (!mAxisTvalid || mAxisTready);
   assign rdIssue = (rdAddr != wrCommit) && (!memQValid || moveOut);

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrPtr[ADDR_WIDTH-1:0]] <= {sAxisTlast, sAxisTkeep, sAxisTdata};
      if (rdIssue) rdWord <= mem[rdAddr[ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rdAddr      <= '0;
         rdPtr       <= '0;
         memQValid   <= 1'b0;
         mAxisTvalid <= 1'b0;
         mAxisTdata  <= '0;
         mAxisTkeep  <= '0;
         mAxisTlast  <= 1'b0;
      end else begin
         memQValid <= rdIssue || (memQValid && !moveOut);
         if (rdIssue) rdAddr <= rdAddr + 1'b1;
         if (consume) rdPtr <= rdPtr + 1'b1;
         if (moveOut) begin
            {mAxisTlast, mAxisTkeep, mAxisTdata} <= rdWord;
            mAxisTvalid <= 1'b1;
         end else if (consume) begin
            mAxisTvalid <= 1'b0;
         end
      end
   end

   // Counters saturate; a clear in the same cycle as an event wins.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         goodPktCount <= '0;
         crcErrCount  <= '0;
         dropCount    <= '0;
      end else if (clearCounters) begin
         goodPktCount <= '0;
         crcErrCount  <= '0;
         dropCount    <= '0;
      end else begin
         if (incGood && goodPktCount != '1) goodPktCount <= goodPktCount + 1'b1;
         if (incCrc && crcErrCount != '1) crcErrCount <= crcErrCount + 1'b1;
         if (incDrop && dropCount != '1) dropCount <= dropCount + 1'b1;
      end
   end
endmodule

// File: tb/tb_aurora_rx_packet_filter.sv
// Bench for aurora_rx_packet_filter: small buffer and narrow counters so overflow and
// saturation are reachable; a scoreboard queue holds every beat expected downstream.
module tb_aurora_rx_packet_filter;
   localparam int AW    = 4;
   localparam int MAXW  = 12;
   localparam int CW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic [31:0]   sAxisTdata = '0;
   logic [3:0]    sAxisTkeep = '0;
   logic [7:0]    sAxisTuser = '0;
   logic          sAxisTlast = 1'b0;
   logic          sAxisTvalid = 1'b0;
   logic [31:0]   mAxisTdata;
   logic [3:0]    mAxisTkeep;
   logic          mAxisTlast;
   logic          mAxisTvalid;
   logic          mAxisTready = 1'b1;
   logic          clearCounters = 1'b0;
   logic [CW-1:0] goodPktCount, crcErrCount, dropCount;
   logic [AW:0]   fifoLevel;
   logic [1:0]    wrStateDbg;

   aurora_rx_packet_filter #(.ADDR_WIDTH(AW), .MAX_PKT_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .resetN(resetN),
      .sAxisTdata(sAxisTdata), .sAxisTkeep(sAxisTkeep), .sAxisTuser(sAxisTuser),
      .sAxisTlast(sAxisTlast), .sAxisTvalid(sAxisTvalid),
      .mAxisTdata(mAxisTdata), .mAxisTkeep(mAxisTkeep), .mAxisTlast(mAxisTlast),
      .mAxisTvalid(mAxisTvalid), .mAxisTready(mAxisTready),
      .clearCounters(clearCounters), .goodPktCount(goodPktCount), .crcErrCount(crcErrCount),
      .dropCount(dropCount), .fifoLevel(fifoLevel), .wrStateDbg(wrStateDbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int nChecks = 0;
   int nFail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [36:0] expQ[$];
   logic [36:0] curWord, prevWord, expWord;
   logic        prevStall = 1'b0;
   int          rxCount = 0;
   int          firstValidCycle = -1;

   assign curWord = {mAxisTlast, mAxisTkeep, mAxisTdata};

   always @(negedge clk) begin
      if (!resetN) begin
         prevStall = 1'b0;
      end else begin
         if (mAxisTvalid && firstValidCycle < 0) firstValidCycle = cycleCnt;
         if (prevStall) begin
            check("stall_valid_held", mAxisTvalid, 1);
            check("stall_word_held", curWord, prevWord);
         end
         if (mAxisTvalid && mAxisTready) begin
            rxCount++;
            nChecks++;
            if (expQ.size() == 0) begin
               nFail++;
               $display("FAIL unexpected_beat: got 'h%0h, expected no beat", curWord);
            end else begin
               expWord = expQ.pop_front();
               if (curWord !== expWord) begin
                  nFail++;
                  $display("FAIL beat_word: got 'h%0h, expected 'h%0h", curWord, expWord);
               end
            end
         end
         prevStall = mAxisTvalid && !mAxisTready;
         prevWord  = curWord;
      end
   end

   // ---------------- drivers ----------------
   logic readyRandom = 1'b0;
   logic readyFixed = 1'b1;

   initial forever begin
      @(posedge clk);
      #1;
      mAxisTready = readyRandom ? 1'($urandom_range(0, 1)) : readyFixed;
   end

   task automatic idle(input int n);
      sAxisTvalid = 1'b0;
      sAxisTlast  = 1'b0;
      sAxisTdata  = $urandom;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendFrame(input int len, input logic [1:0] crc, input logic [3:0] keepLast,
                            input bit pushExp, input int gapPct);
      logic last;
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 99) < gapPct) idle(1);
         last        = (i == len - 1);
         sAxisTvalid = 1'b1;
         sAxisTdata  = $urandom;
         sAxisTkeep  = last ? keepLast : 4'hF;
         sAxisTuser  = last ? {6'($urandom), crc} : 8'($urandom);
         sAxisTlast  = last;
         if (pushExp) expQ.push_back({last, sAxisTkeep, sAxisTdata});
         @(posedge clk);
         #1;
      end
      sAxisTvalid = 1'b0;
      sAxisTlast  = 1'b0;
   endtask

   task automatic pulseClear();
      clearCounters = 1'b1;
      @(posedge clk);
      #1;
      clearCounters = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int maxCycles);
      int n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, expQ.size(), 0);
   endtask

   task automatic checkCounters(input string name, input int g, input int c, input int d);
      check({name, "_good"}, goodPktCount, g);
      check({name, "_crc"}, crcErrCount, c);
      check({name, "_drop"}, dropCount, d);
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // ---------------- directed frame table ----------------
   typedef struct {
      int         len;
      logic [1:0] crc;
      logic [3:0] keepLast;
      bit         pass;
      int         gap;
      int         expGood;
      int         expCrc;
      int         expDrop;
   } vec_t;

   vec_t vecs[10];
   int   lastEdgeCycle;
   int   rx0;
   int   nGood, nCrc, len;
   logic [1:0] crc;

   initial begin
      vecs[0] = '{4,  2'b11, 4'hF,    1, 0,  1, 0, 0};
      vecs[1] = '{4,  2'b11, 4'hF,    1, 0,  2, 0, 0};
      vecs[2] = '{4,  2'b11, 4'hF,    1, 20, 3, 0, 0};
      vecs[3] = '{3,  2'b11, 4'hF,    1, 0,  4, 0, 0};
      vecs[4] = '{4,  2'b01, 4'hF,    0, 0,  4, 1, 0};
      vecs[5] = '{3,  2'b11, 4'hF,    1, 20, 5, 1, 0};
      vecs[6] = '{13, 2'b11, 4'hF,    0, 0,  5, 1, 1};
      vecs[7] = '{1,  2'b11, 4'b0011, 1, 5,  6, 1, 1};
      vecs[8] = '{13, 2'b01, 4'hF,    0, 0,  6, 1, 2};
      vecs[9] = '{1,  2'b11, 4'b1000, 1, 20, 7, 1, 2};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", mAxisTvalid, 0);
      check("rst_data", mAxisTdata, 0);
      check("rst_level", fifoLevel, 0);
      check("rst_state", wrStateDbg, 0);
      checkCounters("rst", 0, 0, 0);
      resetN = 1'b1;
      idle(2);

      // back-to-back pass frames, CRC reject, over-length drops, keep on 1-beat frames
      firstValidCycle = -1;
      lastEdgeCycle   = 0;
      rx0 = rxCount;
      for (int i = 0; i < 10; i++) begin
         sendFrame(vecs[i].len, vecs[i].crc, vecs[i].keepLast, vecs[i].pass, 0);
         if (i == 0) lastEdgeCycle = cycleCnt;
         checkCounters($sformatf("vec%0d", i), vecs[i].expGood, vecs[i].expCrc, vecs[i].expDrop);
         if (vecs[i].gap > 0) idle(vecs[i].gap);
      end
      waitDrain("table_drain", 200);
      idle(4);
      check("first_latency", firstValidCycle - lastEdgeCycle, 2);
      check("table_rx_words", rxCount - rx0, 20);
      check("table_level", fifoLevel, 0);

      // overflow: second frame cannot fit while the consumer is stalled
      pulseClear();
      readyFixed = 1'b0;
      idle(2);
      rx0 = rxCount;
      sendFrame(10, 2'b11, 4'hF, 1, 0);
      sendFrame(10, 2'b11, 4'hF, 0, 0);
      idle(4);
      checkCounters("ovf", 1, 0, 1);
      check("ovf_level", fifoLevel, 10);
      check("ovf_valid_stalled", mAxisTvalid, 1);
      check("ovf_no_reads", rxCount - rx0, 0);
      readyFixed = 1'b1;
      waitDrain("ovf_drain", 100);
      idle(5);
      check("ovf_rx_words", rxCount - rx0, 10);
      check("ovf_level_after", fifoLevel, 0);

      // random frames with random back-pressure; only send when the frame fits
      pulseClear();
      readyRandom = 1'b1;
      nGood = 0;
      nCrc  = 0;
      for (int f = 0; f < 200; f++) begin
         int waitN;
         len   = $urandom_range(1, MAXW);
         crc   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         waitN = 0;
         while (expQ.size() + len > DEPTH && waitN < 2000) begin
            idle(1);
            waitN++;
         end
         if (waitN >= 2000) begin
            nChecks++;
            nFail++;
            $display("FAIL rand_space_wait: got %0d queued words, expected at most %0d", expQ.size(), DEPTH - len);
         end
         sendFrame(len, crc, 4'($urandom_range(1, 15)), crc == 2'b11, 20);
         if (crc == 2'b11) nGood++;
         else nCrc++;
         idle($urandom_range(0, 2));
      end
      readyRandom = 1'b0;
      readyFixed  = 1'b1;
      waitDrain("rand_drain", 500);
      idle(4);
      checkCounters("rand", sat(nGood), sat(nCrc), 0);
      check("rand_level", fifoLevel, 0);

      // reset mid-output and mid-frame
      pulseClear();
      readyFixed = 1'b0;
      sendFrame(5, 2'b11, 4'hF, 1, 0);
      idle(3);
      check("mid_out_valid", mAxisTvalid, 1);
      for (int i = 0; i < 3; i++) begin
         sAxisTvalid = 1'b1;
         sAxisTlast  = 1'b0;
         sAxisTkeep  = 4'hF;
         sAxisTdata  = $urandom;
         @(posedge clk);
         #1;
      end
      check("mid_frame_state", wrStateDbg, 1);
      resetN = 1'b0;
      #1;
      check("arst_valid", mAxisTvalid, 0);
      check("arst_data", mAxisTdata, 0);
      check("arst_keep", mAxisTkeep, 0);
      check("arst_last", mAxisTlast, 0);
      check("arst_level", fifoLevel, 0);
      check("arst_state", wrStateDbg, 0);
      checkCounters("arst", 0, 0, 0);
      expQ.delete();
      sAxisTvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetN     = 1'b1;
      readyFixed = 1'b1;
      idle(2);
      checkCounters("post_rst", 0, 0, 0);
      check("post_rst_valid", mAxisTvalid, 0);
      rx0 = rxCount;
      sendFrame(6, 2'b11, 4'b0111, 1, 0);
      waitDrain("post_rst_drain", 50);
      idle(3);
      check("post_rst_rx_words", rxCount - rx0, 6);
      check("post_rst_good", goodPktCount, 1);

      // saturation and clear-wins
      pulseClear();
      for (int i = 0; i < CMAX + 1; i++) begin
         sendFrame(1, 2'b10, 4'hF, 0, 0);
         if (i == CMAX - 1) check("sat_reach", crcErrCount, CMAX);
      end
      check("sat_hold", crcErrCount, CMAX);
      sendFrame(2, 2'b11, 4'hF, 1, 0);
      check("pre_clear_good", goodPktCount, 1);
      clearCounters = 1'b1;
      sendFrame(1, 2'b11, 4'b0001, 1, 0);
      clearCounters = 1'b0;
      checkCounters("clear_wins", 0, 0, 0);
      waitDrain("final_drain", 50);
      idle(5);
      check("final_level", fifoLevel, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
